// File: rtl/reg_dump_engine_pkg.sv
// Shared types and constants for the register dump engine.
package reg_dump_engine_pkg;

  localparam logic [31:0] HALT_PC_DEFAULT = 32'h0000_0FFC;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_EMIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/reg_dump_engine_shadow_ram.sv
// Shadow copy of the register file from the previous dump.
// Combinational read, one synchronous write port, asynchronous clear.
module reg_shadow_ram #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 32,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c
);

  logic [WIDTH-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata_c = mem_q[addr];

endmodule

// File: rtl/reg_dump_engine.sv
// Scans a register file and streams every register (full dump) or only the
// ones changed since the last dump, always terminated by the last register.
module reg_dump_engine
  import reg_dump_engine_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter logic [31:0] HALT_PC  = HALT_PC_DEFAULT,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             auto_en,
  input  logic [31:0]      pc,
  input  logic             mode,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_index,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [AW-1:0]    out_index_q, out_index_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mode_q, mode_d;
  logic             armed_q, armed_d;

  logic             auto_hit_c, trigger_c, xfer_c, emit_c, shadow_we_c;
  logic [WIDTH-1:0] shadow_rdata_c;

  reg_shadow_ram #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_shadow (
    .clk     (clk),
    .reset   (reset),
    .we      (shadow_we_c),
    .addr    (rd_addr_q),
    .wdata   (rd_data),
    .rdata_c (shadow_rdata_c)
  );

  assign auto_hit_c = auto_en && armed_q && (pc == HALT_PC);
  assign trigger_c  = start || auto_hit_c;
  assign xfer_c     = out_valid_q && out_ready;
  // The last register is always emitted so every stream has a terminator.
  assign emit_c     = !mode_q || (rd_data != shadow_rdata_c) || (rd_addr_q == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (trigger_c) state_d = ST_SCAN;
      ST_SCAN:   if (emit_c) state_d = ST_EMIT;
      ST_EMIT:   if (xfer_c) state_d = (out_index_q == LAST_IDX) ? ST_FINISH : ST_SCAN;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_addr_d   = rd_addr_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    mode_d      = mode_q;
    armed_d     = armed_q;
    shadow_we_c = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FINISH);
    // Re-arm once the PC has moved off the halt address.
    if (pc != HALT_PC) armed_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (trigger_c) begin
          mode_d    = mode;
          rd_addr_d = '0;
          if (auto_hit_c) armed_d = 1'b0;
        end
      end
      ST_SCAN: begin
        shadow_we_c = 1'b1;
        if (emit_c) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_data;
          out_index_d = rd_addr_q;
          out_last_d  = (rd_addr_q == LAST_IDX);
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      ST_EMIT: begin
        if (xfer_c) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_index_q != LAST_IDX) rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_q   <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      rd_addr_q   <= rd_addr_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mode_q      <= mode_d;
      armed_q     <= armed_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
